// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    // Writeback source identity; also the encoding of the arbiter's last-grant pointer.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

    // True for any register other than the hard-wired zero register x0.
    function automatic logic reg_is_live(input logic [REG_AW-1:0] addr);
        return addr != REG_AW'(0);
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback-request, register-file and scoreboard signals of the scheduler.
interface regfile_wb_scheduler_if #(
    parameter int unsigned XLEN  = regfile_wb_scheduler_pkg::XLEN,
    parameter int unsigned NREGS = regfile_wb_scheduler_pkg::NREGS
);
    import regfile_wb_scheduler_pkg::*;

    // Issue request and hazard response
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] issue_rs1;
    logic [REG_AW-1:0] issue_rs2;
    logic              issue_stall;

    // ALU writeback request
    logic              alu_valid;
    logic [REG_AW-1:0] alu_wa;
    logic [XLEN-1:0]   alu_wd;
    logic              alu_ready;

    // Load-unit writeback request
    logic              lsu_valid;
    logic [REG_AW-1:0] lsu_wa;
    logic [XLEN-1:0]   lsu_wd;
    logic              lsu_ready;

    // Register file write port and scoreboard view
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [XLEN-1:0]   rf_wd;
    logic [NREGS-1:0]  busy;

    // Pipeline side: drives issue and writeback requests.
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_wa, alu_wd,
        output lsu_valid, lsu_wa, lsu_wd,
        input  issue_stall, alu_ready, lsu_ready,
        input  rf_we, rf_wa, rf_wd, busy
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_wa, alu_wd,
        input  lsu_valid, lsu_wa, lsu_wd,
        output issue_stall, alu_ready, lsu_ready,
        output rf_we, rf_wa, rf_wd, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs LSU) with a one-bit last-grant pointer.
module rr_arb2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_alu,
    input  logic i_req_lsu,
    output logic o_gnt_alu_c,
    output logic o_gnt_lsu_c
);

    wb_src_t r_last_grant;
    logic    w_any_grant;

    assign w_any_grant = o_gnt_alu_c | o_gnt_lsu_c;

    // Grant in the same cycle; on contention the side not granted last wins.
    always_comb begin
        o_gnt_alu_c = 1'b0;
        o_gnt_lsu_c = 1'b0;
        if (i_req_alu && i_req_lsu) begin
            if (r_last_grant == WB_LSU) begin
                o_gnt_alu_c = 1'b1;
            end else begin
                o_gnt_lsu_c = 1'b1;
            end
        end else if (i_req_alu) begin
            o_gnt_alu_c = 1'b1;
        end else if (i_req_lsu) begin
            o_gnt_lsu_c = 1'b1;
        end
    end

    // Pointer moves only on a grant; reset value makes the ALU win first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= WB_LSU;
        end else if (w_any_grant) begin
            r_last_grant <= o_gnt_lsu_c ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler: arbitrates ALU/LSU writes onto the register file
// and keeps a pending-write scoreboard that stalls hazardous issues.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN  = regfile_wb_scheduler_pkg::XLEN,
    parameter int unsigned NREGS = regfile_wb_scheduler_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_scheduler_if.slave bus
);
    import regfile_wb_scheduler_pkg::*;

    logic              w_gnt_alu;
    logic              w_gnt_lsu;
    logic              w_rf_we;
    logic [REG_AW-1:0] w_rf_wa;
    logic [XLEN-1:0]   w_rf_wd;

    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_rd_hit;
    logic              w_stall;
    logic              w_set;
    logic              w_clr;

    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (reset),
        .i_req_alu   (bus.alu_valid),
        .i_req_lsu   (bus.lsu_valid),
        .o_gnt_alu_c (w_gnt_alu),
        .o_gnt_lsu_c (w_gnt_lsu)
    );

    // Steer the granted requester onto the write port; idle port reads all zero.
    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = '0;
        w_rf_wd = '0;
        if (w_gnt_alu) begin
            w_rf_we = 1'b1;
            w_rf_wa = bus.alu_wa;
            w_rf_wd = bus.alu_wd;
        end else if (w_gnt_lsu) begin
            w_rf_we = 1'b1;
            w_rf_wa = bus.lsu_wa;
            w_rf_wd = bus.lsu_wd;
        end
    end

    // RAW/WAW hazard detect against the registered scoreboard only (no bypass).
    always_comb begin
        w_rs1_hit = reg_is_live(bus.issue_rs1) && r_busy[bus.issue_rs1];
        w_rs2_hit = reg_is_live(bus.issue_rs2) && r_busy[bus.issue_rs2];
        w_rd_hit  = reg_is_live(bus.issue_rd)  && r_busy[bus.issue_rd];
        w_stall   = bus.issue_valid && (w_rs1_hit || w_rs2_hit || w_rd_hit);
        w_set     = bus.issue_valid && !w_stall && reg_is_live(bus.issue_rd);
        w_clr     = w_rf_we && reg_is_live(w_rf_wa);
    end

    // Next scoreboard: clear the written register, then set the issued one so a same-register set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[w_rf_wa] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; reset drops every pending write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.alu_ready   = w_gnt_alu;
    assign bus.lsu_ready   = w_gnt_lsu;
    assign bus.rf_we       = w_rf_we;
    assign bus.rf_wa       = w_rf_wa;
    assign bus.rf_wd       = w_rf_wd;
    assign bus.issue_stall = w_stall;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus
// randomized traffic against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.XLEN(32), .NREGS(32)) bus ();

    regfile_wb_scheduler #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit [31:0] m_busy;
    bit        m_last_lsu;   // 1: LSU was granted most recently
    bit        e_ga, e_gl, e_stall;
    bit        m_ga, m_gl;   // grants seen in the previous cycle (driver hold rule)

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r];
    endfunction

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic zero_inputs();
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.alu_valid = 1'b0; bus.alu_wa = '0; bus.alu_wd = '0;
        bus.lsu_valid = 1'b0; bus.lsu_wa = '0; bus.lsu_wd = '0;
    endtask

    // Compare every DUT output against the model at the falling edge.
    task automatic check_now();
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        @(negedge clk);
        e_ga = bus.alu_valid && (!bus.lsu_valid || m_last_lsu);
        e_gl = bus.lsu_valid && !e_ga;
        exp_wa = e_ga ? bus.alu_wa : (e_gl ? bus.lsu_wa : 5'd0);
        exp_wd = e_ga ? bus.alu_wd : (e_gl ? bus.lsu_wd : 32'd0);
        e_stall = bus.issue_valid && (hit(bus.issue_rs1) || hit(bus.issue_rs2) || hit(bus.issue_rd));
        chk("alu_ready",   64'(bus.alu_ready),   64'(e_ga));
        chk("lsu_ready",   64'(bus.lsu_ready),   64'(e_gl));
        chk("rf_we",       64'(bus.rf_we),       64'(e_ga | e_gl));
        chk("rf_wa",       64'(bus.rf_wa),       64'(exp_wa));
        chk("rf_wd",       64'(bus.rf_wd),       64'(exp_wd));
        chk("issue_stall", 64'(bus.issue_stall), 64'(e_stall));
        chk("busy",        64'(bus.busy),        64'(m_busy));
    endtask

    // Apply the spec rules for the edge, then move to just after it.
    task automatic finish_cycle();
        if (e_ga) begin
            if (bus.alu_wa != 5'd0) m_busy[bus.alu_wa] = 1'b0;
            m_last_lsu = 1'b0;
        end else if (e_gl) begin
            if (bus.lsu_wa != 5'd0) m_busy[bus.lsu_wa] = 1'b0;
            m_last_lsu = 1'b1;
        end
        if (bus.issue_valid && !e_stall && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
        m_ga = e_ga;
        m_gl = e_gl;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_now();
        finish_cycle();
    endtask

    // Asynchronous reset asserted between edges, held across one posedge.
    task automatic mid_reset();
        zero_inputs();
        #2;
        reset = 1'b1;
        #1;
        chk("reset_busy_now", 64'(bus.busy), 64'd0);
        chk("reset_rf_we",    64'(bus.rf_we), 64'd0);
        m_busy = '0; m_last_lsu = 1'b1; m_ga = 1'b0; m_gl = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        zero_inputs();
        reset = 1'b1;
        m_busy = '0; m_last_lsu = 1'b1; m_ga = 1'b0; m_gl = 1'b0;
        #1;
        chk("rst_busy",  64'(bus.busy),        64'd0);
        chk("rst_rf_we", 64'(bus.rf_we),       64'd0);
        chk("rst_rf_wa", 64'(bus.rf_wa),       64'd0);
        chk("rst_rf_wd", 64'(bus.rf_wd),       64'd0);
        chk("rst_stall", 64'(bus.issue_stall), 64'd0);
        chk("rst_ready", 64'({bus.alu_ready, bus.lsu_ready}), 64'd0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention after reset: ALU first, then LSU
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd3; bus.alu_wd = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd4; bus.lsu_wd = 32'h22;
        check_now();
        chk("s036_c1_rf_wa",     64'(bus.rf_wa),     64'd3);
        chk("s036_c1_alu_ready", 64'(bus.alu_ready), 64'd1);
        finish_cycle();
        check_now();
        chk("s036_c2_rf_wa",     64'(bus.rf_wa),     64'd4);
        chk("s036_c2_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        chk("s036_c2_rf_wd",     64'(bus.rf_wd),     64'h22);
        finish_cycle();
        zero_inputs();

        // RAW stall on x5 until its write lands
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        check_now();
        chk("s037_issue_ok", 64'(bus.issue_stall), 64'd0);
        finish_cycle();
        bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd5;
        check_now();
        chk("s037_raw_stall", 64'(bus.issue_stall), 64'd1);
        chk("s037_busy5",     64'(bus.busy[5]),     64'd1);
        finish_cycle();
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 32'h55;
        check_now();
        chk("s037_no_bypass", 64'(bus.issue_stall), 64'd1);
        finish_cycle();
        bus.alu_valid = 1'b0;
        check_now();
        chk("s037_stall_drop", 64'(bus.issue_stall), 64'd0);
        finish_cycle();
        zero_inputs();

        // Set and clear of x7 in the same cycle: set wins
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd7; bus.lsu_wd = 32'h77;
        step();
        zero_inputs();
        chk("s038_set_wins", 64'(bus.busy[7]), 64'd1);

        // x0 traffic never touches the scoreboard
        bus.issue_valid = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd0; bus.alu_wd = 32'hDEADBEEF;
        check_now();
        chk("s039_stall", 64'(bus.issue_stall), 64'd0);
        chk("s039_rf_we", 64'(bus.rf_we),       64'd1);
        chk("s039_rf_wa", 64'(bus.rf_wa),       64'd0);
        chk("s039_rf_wd", 64'(bus.rf_wd),       64'hDEADBEEF);
        finish_cycle();
        zero_inputs();
        chk("s039_busy0",  64'(bus.busy[0]), 64'd0);
        chk("s039_busy_x", 64'(bus.busy),    64'h80);

        // Pending x9/x10 wiped by a mid-cycle reset; ALU wins next contention
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        bus.issue_rd = 5'd10;
        step();
        zero_inputs();
        chk("s040_busy9_10", 64'(bus.busy[10:9]), 64'd3);
        mid_reset();
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd11; bus.alu_wd = 32'hA;
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd12; bus.lsu_wd = 32'hB;
        check_now();
        chk("s040_alu_first", 64'(bus.alu_ready), 64'd1);
        finish_cycle();
        zero_inputs();

        // LSU alone three times, then contention goes to the ALU
        for (int k = 0; k < 3; k++) begin
            bus.lsu_valid = 1'b1; bus.lsu_wa = 5'(13 + k); bus.lsu_wd = 32'(k);
            check_now();
            chk("s041_lsu_alone", 64'(bus.lsu_ready), 64'd1);
            finish_cycle();
        end
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd20; bus.alu_wd = 32'hC;
        check_now();
        chk("s041_alu_wins", 64'(bus.alu_ready), 64'd1);
        chk("s041_lsu_wait", 64'(bus.lsu_ready), 64'd0);
        finish_cycle();
        zero_inputs();
        m_ga = 1'b0; m_gl = 1'b0;

        // Randomized traffic; ungranted requests are held stable
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) mid_reset();
            if (!bus.alu_valid || m_ga) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_wa    = rand_reg();
                bus.alu_wd    = $urandom();
            end
            if (!bus.lsu_valid || m_gl) begin
                bus.lsu_valid = 1'($urandom_range(0, 1));
                bus.lsu_wa    = rand_reg();
                bus.lsu_wd    = $urandom();
            end
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd    = rand_reg();
            bus.issue_rs1   = rand_reg();
            bus.issue_rs2   = rand_reg();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
